// File: rtl/chi_link_tx_channel.sv
`default_nettype none
// ============================================================================
// Module   : chi_link_tx_channel
// Purpose  : Transmit side of one CHI link-layer channel. Accepts upstream
//            flits, spends one link credit per flit, turns LCRDV pulses into
//            credit-manager increments, and on deactivation returns every held
//            credit as an all-zero LCrdReturn flit before reporting drained.
// Revision : 1.0 - initial release
// ============================================================================
module chi_link_tx_channel #(
    parameter int FLIT_WIDTH  = 117,
    parameter int MAX_CREDITS = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic                  in_ready,
    input  logic                  link_run,
    input  logic                  link_deact,
    input  logic                  lcrdv,
    output logic                  flitpend,
    output logic                  flitv,
    output logic [FLIT_WIDTH-1:0] flit,
    input  logic [3:0]            cur_credits,
    output logic                  incr_credits,
    output logic                  dec_credits,
    output logic                  deact_done,
    output logic                  err_credit_ovf
);

    localparam logic [3:0] c_MAX_CRD = 4'(MAX_CREDITS);

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DEACT   = 2'd2,
        ST_DRAINED = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_send;
    logic                  w_ovf;
    logic                  r_flitv;
    logic [FLIT_WIDTH-1:0] r_flit;
    logic                  r_flitpend;
    logic                  r_incr;
    logic                  r_deact_done;
    logic                  r_err_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, send decision and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_send      = 1'b0;
        in_ready    = 1'b0;
        dec_credits = 1'b0;

        // A send in a reset cycle is never launched, so the credit is not spent
        if (resetn && (cur_credits != 4'd0)) begin
            w_send = ((r_state == ST_RUN) && in_valid) || (r_state == ST_DEACT);
        end
        in_ready    = w_send && (r_state == ST_RUN);
        dec_credits = w_send;

        case (r_state)
            ST_STOP: begin
                if (link_run) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (link_deact)     w_state_nxt = ST_DEACT;
                else if (!link_run) w_state_nxt = ST_STOP;
            end
            ST_DEACT: begin
                // Drained only once no credit is held or still in flight
                if ((cur_credits == 4'd0) && !r_incr && !lcrdv) w_state_nxt = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (lcrdv)            w_state_nxt = ST_DEACT;
                else if (!link_deact) w_state_nxt = ST_STOP;
            end
            default: w_state_nxt = ST_STOP;
        endcase
    end

    // A credit arriving at the ceiling with none being spent cannot be counted
    assign w_ovf = lcrdv && (cur_credits == c_MAX_CRD) && !w_send;

    // Link-side registers, credit capture and status flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_flitv      <= 1'b0;
            r_flit       <= '0;
            r_flitpend   <= 1'b0;
            r_incr       <= 1'b0;
            r_deact_done <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_flitv <= w_send;
            if (w_send) begin
                r_flit <= (r_state == ST_RUN) ? in_flit : '0;
            end
            // Follows the next state so FLITPEND leads the first FLITV
            r_flitpend   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DEACT);
            r_incr       <= lcrdv && !w_ovf;
            r_deact_done <= (r_state == ST_DRAINED);
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign flitv          = r_flitv;
    assign flit           = r_flit;
    assign flitpend       = r_flitpend;
    assign incr_credits   = r_incr;
    assign deact_done     = r_deact_done;
    assign err_credit_ovf = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chi_link_tx_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_chi_link_tx_channel
// Purpose  : Self-checking bench for chi_link_tx_channel. A behavioural model
//            of the link channel and an external credit manager predicts every
//            output each cycle; directed scenarios are followed by random ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chi_link_tx_channel;

    localparam int FW  = 117;
    localparam int MAX = 14;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          in_ready;
    logic          link_run;
    logic          link_deact;
    logic          lcrdv;
    logic          flitpend;
    logic          flitv;
    logic [FW-1:0] flit;
    logic [3:0]    cur_credits;
    logic          incr_credits;
    logic          dec_credits;
    logic          deact_done;
    logic          err_credit_ovf;

    int n_chk = 0;
    int n_err = 0;

    // Model of the channel: link phase as a name, plus expected registered outputs
    string         m_mode = "STOP";
    int            cm_cnt = 0;
    logic          exp_flitv = 1'b0;
    logic [FW-1:0] exp_flit = '0;
    logic          exp_pend = 1'b0;
    logic          exp_incr = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_err = 1'b0;

    chi_link_tx_channel #(.FLIT_WIDTH(FW), .MAX_CREDITS(MAX)) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_flit        (in_flit),
        .in_ready       (in_ready),
        .link_run       (link_run),
        .link_deact     (link_deact),
        .lcrdv          (lcrdv),
        .flitpend       (flitpend),
        .flitv          (flitv),
        .flit           (flit),
        .cur_credits    (cur_credits),
        .incr_credits   (incr_credits),
        .dec_credits    (dec_credits),
        .deact_done     (deact_done),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] rnd_flit();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[FW-1:0];
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the handshake,
    // advance the model at the rising edge, check registered outputs at the next fall.
    task automatic cycle(input logic rn, input logic run, input logic deact,
                         input logic lc, input logic v, input logic [FW-1:0] f);
        logic  m_send;
        logic  ovf;
        string nxt;
        resetn      = rn;
        link_run    = run;
        link_deact  = deact;
        lcrdv       = lc;
        in_valid    = v;
        in_flit     = f;
        cur_credits = 4'(cm_cnt);
        #1;
        m_send = rn && (cm_cnt != 0) && ((m_mode == "RUN" && v) || m_mode == "DEACT");
        chk("in_ready", in_ready, m_send && (m_mode == "RUN"));
        chk("dec_credits", dec_credits, m_send);
        @(posedge clk);
        if (!rn) begin
            m_mode    = "STOP";
            cm_cnt    = 0;
            exp_flitv = 1'b0;
            exp_flit  = '0;
            exp_pend  = 1'b0;
            exp_incr  = 1'b0;
            exp_done  = 1'b0;
            exp_err   = 1'b0;
        end else begin
            ovf = lc && (cm_cnt == MAX) && !m_send;
            nxt = m_mode;
            if (m_mode == "STOP") begin
                if (run) nxt = "RUN";
            end else if (m_mode == "RUN") begin
                if (deact)     nxt = "DEACT";
                else if (!run) nxt = "STOP";
            end else if (m_mode == "DEACT") begin
                if (cm_cnt == 0 && !exp_incr && !lc) nxt = "DRAINED";
            end else begin
                if (lc)          nxt = "DEACT";
                else if (!deact) nxt = "STOP";
            end
            cm_cnt = cm_cnt + int'(exp_incr) - int'(m_send);
            if (m_mode == "RUN" && nxt == "STOP") cm_cnt = 0;
            exp_done  = (m_mode == "DRAINED");
            exp_flitv = m_send;
            if (m_send) exp_flit = (m_mode == "RUN") ? f : '0;
            if (ovf) exp_err = 1'b1;
            exp_incr = lc && !ovf;
            exp_pend = (nxt == "RUN") || (nxt == "DEACT");
            m_mode   = nxt;
        end
        @(negedge clk);
        chk("flitv", flitv, exp_flitv);
        chk("flit", flit, exp_flit);
        chk("flitpend", flitpend, exp_pend);
        chk("incr_credits", incr_credits, exp_incr);
        chk("deact_done", deact_done, exp_done);
        chk("err_credit_ovf", err_credit_ovf, exp_err);
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fc;
        logic          v, lc, rn;
        resetn = 1'b0; link_run = 1'b0; link_deact = 1'b0; lcrdv = 1'b0;
        in_valid = 1'b0; in_flit = '0; cur_credits = 4'd0;
        @(negedge clk);
        do_reset();

        // Credit receive: three LCRDV pulses while running, no traffic
        cycle(1, 1, 0, 0, 0, '0);
        repeat (3) cycle(1, 1, 0, 1, 0, '0);
        repeat (3) cycle(1, 1, 0, 0, 0, '0);
        chk("credits_after_3", 128'(cm_cnt), 128'd3);

        // Throughput vs credits: two credits, three flits queued
        do_reset();
        cycle(1, 1, 0, 0, 0, '0);
        repeat (2) cycle(1, 1, 0, 1, 0, '0);
        repeat (2) cycle(1, 1, 0, 0, 0, '0);
        fa = rnd_flit(); fb = rnd_flit(); fc = rnd_flit();
        cycle(1, 1, 0, 0, 1, fa);
        cycle(1, 1, 0, 0, 1, fb);
        repeat (3) cycle(1, 1, 0, 0, 1, fc);
        cycle(1, 1, 0, 1, 1, fc);
        cycle(1, 1, 0, 0, 1, fc);
        cycle(1, 1, 0, 0, 0, '0);
        repeat (2) cycle(1, 1, 0, 0, 0, '0);

        // Simultaneous increment and decrement at one credit
        cycle(1, 1, 0, 1, 0, '0);
        cycle(1, 1, 0, 1, 1, rnd_flit());
        cycle(1, 1, 0, 0, 1, rnd_flit());
        cycle(1, 1, 0, 0, 1, rnd_flit());
        repeat (2) cycle(1, 1, 0, 0, 0, '0);

        // Deactivation with four credits held, then a late credit
        do_reset();
        cycle(1, 1, 0, 0, 0, '0);
        repeat (4) cycle(1, 1, 0, 1, 0, '0);
        repeat (2) cycle(1, 1, 0, 0, 0, '0);
        repeat (9) cycle(1, 0, 1, 0, 1, rnd_flit());
        chk("drained_mode", 128'(m_mode == "DRAINED"), 128'd1);
        cycle(1, 0, 1, 1, 0, '0);
        repeat (8) cycle(1, 0, 1, 0, 0, '0);
        repeat (2) cycle(1, 0, 0, 0, 0, '0);

        // Overflow at the credit ceiling, sticky until reset
        do_reset();
        cycle(1, 1, 0, 0, 0, '0);
        repeat (MAX) cycle(1, 1, 0, 1, 0, '0);
        repeat (2) cycle(1, 1, 0, 0, 0, '0);
        cycle(1, 1, 0, 1, 0, '0);
        repeat (3) cycle(1, 1, 0, 0, 0, '0);
        chk("credits_at_ceiling", 128'(cm_cnt), 128'(MAX));
        do_reset();
        cycle(1, 0, 0, 0, 0, '0);

        // Mid-operation reset during a burst
        cycle(1, 1, 0, 0, 0, '0);
        repeat (4) cycle(1, 1, 0, 1, 0, '0);
        repeat (2) cycle(1, 1, 0, 0, 1, rnd_flit());
        cycle(0, 1, 0, 0, 1, rnd_flit());
        repeat (2) cycle(1, 0, 0, 0, 1, rnd_flit());
        cycle(1, 1, 0, 0, 1, rnd_flit());

        // Random traffic across run / deactivate / stop phases
        for (int ph = 0; ph < 16; ph++) begin
            for (int c = 0; c < 40; c++) begin
                v  = ($urandom_range(0, 3) != 0);
                lc = ((cm_cnt + int'(exp_incr)) < MAX) && ($urandom_range(0, 2) == 0);
                rn = ($urandom_range(0, 79) != 0);
                cycle(rn, 1, 0, lc, v, rnd_flit());
            end
            if (ph % 3 == 2) begin
                repeat (2) cycle(1, 0, 0, 0, 1, rnd_flit());
            end else begin
                for (int c = 0; c < 30; c++) begin
                    lc = (c < 15) && ((cm_cnt + int'(exp_incr)) < MAX) &&
                         ($urandom_range(0, 5) == 0);
                    cycle(1, 0, 1, lc, $urandom_range(0, 1) == 1, rnd_flit());
                end
                repeat (2) cycle(1, 0, 0, 0, 0, '0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
